// File: rtl/control_pila.sv
// control_pila: return-address stack sequencer arbitrating call/ret/reti against the interrupt line.
module control_pila #(
  parameter int ADDR_W = 10,
  parameter int DEPTH = 16,
  parameter logic [ADDR_W-1:0] INT_VEC = 10'h3F0,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call,
  input  logic              ret,
  input  logic              reti,
  input  logic [ADDR_W-1:0] pc_plus1,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              int_req,
  input  logic [ADDR_W-1:0] stack_top,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W-1:0] push_addr,
  output logic [1:0]        pc_sel,
  output logic [ADDR_W-1:0] pc_vec,
  output logic              int_ack,
  output logic              stall,
  output logic              in_isr,
  output logic [CNT_W-1:0]  depth,
  output logic              fault
);
  typedef enum logic [1:0] {RUN, INT_ENTRY, INT_JUMP, FAULT} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] saved;
  logic run, full, empty, multi, any_req, do_call, do_pop, go_fault, go_int;
  always_comb begin
    run = state == RUN;
    full = cnt == CNT_W'(DEPTH);
    empty = cnt == '0;
    multi = (call && ret) || (call && reti) || (ret && reti);
    any_req = call || ret || reti;
    do_call = run && !multi && call && !full;
    do_pop = run && !multi && !empty && (ret || (reti && in_isr));
    // any decoder request that cannot be honoured safely is fatal
    go_fault = run && any_req && !do_call && !do_pop;
    go_int = run && !any_req && int_req && !in_isr && !full;
  end
  assign push = do_call || state == INT_ENTRY;
  assign pop = do_pop;
  assign push_addr = state == INT_ENTRY ? saved : pc_plus1;
  assign pc_sel = state == INT_JUMP ? 2'b10 : do_pop ? 2'b01 : 2'b00;
  assign pc_vec = INT_VEC;
  assign int_ack = state == INT_JUMP;
  assign stall = state == INT_ENTRY || state == FAULT;
  assign depth = cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt <= '0;
      saved <= '0;
      in_isr <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= go_fault ? FAULT : go_int ? INT_ENTRY : state == INT_ENTRY ? INT_JUMP :
               state == INT_JUMP ? RUN : state;
      cnt <= push ? cnt + CNT_W'(1) : pop ? cnt - CNT_W'(1) : cnt;
      if (go_int) saved <= pc_next;
      if (state == INT_JUMP) in_isr <= 1'b1;
      else if (do_pop && reti) in_isr <= 1'b0;
      fault <= fault || go_fault;
    end
  end
endmodule

// File: tb/tb_control_pila.sv
// tb_control_pila: randomized scoreboard bench for control_pila against a queue-based stack model.
module tb_control_pila;
  logic clk = 0, reset = 0, call = 0, ret = 0, reti = 0, int_req = 0;
  logic [9:0] pc_plus1 = 0, pc_next = 0, stack_top = 0;
  logic push, pop, int_ack, stall, in_isr, fault;
  logic [9:0] push_addr, pc_vec;
  logic [1:0] pc_sel;
  logic [4:0] depth;
  control_pila dut (.clk(clk), .reset(reset), .call(call), .ret(ret), .reti(reti),
    .pc_plus1(pc_plus1), .pc_next(pc_next), .int_req(int_req), .stack_top(stack_top),
    .push(push), .pop(pop), .push_addr(push_addr), .pc_sel(pc_sel), .pc_vec(pc_vec),
    .int_ack(int_ack), .stall(stall), .in_isr(in_isr), .depth(depth), .fault(fault));
  always #5 clk = ~clk;
  typedef struct packed {
    logic push, pop;
    logic [9:0] addr;
    logic [1:0] sel;
    logic ack, stall, isr;
    logic [4:0] dep;
    logic flt;
  } exp_t;
  exp_t q[$];
  logic [9:0] stk[$];
  bit m_isr, m_flt, last_ack;
  int phase;
  logic [9:0] m_saved;
  int vectors = 0, miscompares = 0;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // drive one cycle and push the model's expected outputs for it
  task automatic cyc(input bit c, r, ri, ir, rst, input logic [9:0] p1, pn);
    exp_t e;
    @(posedge clk);
    #1;
    call = c; ret = r; reti = ri; int_req = ir; reset = rst; pc_plus1 = p1; pc_next = pn;
    stack_top = stk.size() > 0 ? stk[$] : 10'($urandom);
    e = '0;
    e.dep = 5'(stk.size());
    e.isr = m_isr;
    e.flt = m_flt;
    if (!rst) begin
      stk.delete(); m_isr = 0; m_flt = 0; phase = 0; e = '0;
    end else if (m_flt) e.stall = 1;
    else if (phase == 1) begin
      e.stall = 1; e.push = 1; e.addr = m_saved; stk.push_back(m_saved); phase = 2;
    end else if (phase == 2) begin
      e.sel = 2; e.ack = 1; m_isr = 1; phase = 0;
    end else if (int'(c) + int'(r) + int'(ri) > 1) m_flt = 1;
    else if (c) begin
      if (stk.size() == 16) m_flt = 1;
      else begin e.push = 1; e.addr = p1; stk.push_back(p1); end
    end else if (r) begin
      if (stk.size() == 0) m_flt = 1;
      else begin e.pop = 1; e.sel = 1; void'(stk.pop_back()); end
    end else if (ri) begin
      if (!m_isr || stk.size() == 0) m_flt = 1;
      else begin e.pop = 1; e.sel = 1; void'(stk.pop_back()); m_isr = 0; end
    end else if (ir && !m_isr && stk.size() < 16) begin
      phase = 1; m_saved = pn;
    end
    last_ack = e.ack;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("push", push, e.push);
      cmp("pop", pop, e.pop);
      if (e.push) cmp("push_addr", push_addr, e.addr);
      cmp("pc_sel", pc_sel, e.sel);
      cmp("pc_vec", pc_vec, 10'h3F0);
      cmp("int_ack", int_ack, e.ack);
      cmp("stall", stall, e.stall);
      cmp("in_isr", in_isr, e.isr);
      cmp("depth", depth, e.dep);
      cmp("fault", fault, e.flt);
    end
  end
  initial begin
    bit ir, c, r, ri;
    int pct;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 10'h012, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 10'h055);
    cyc(0, 0, 0, 1, 1, 0, 10'h0AA);
    cyc(0, 0, 0, 1, 1, 0, 10'h0AA);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 10'h100, 10'h055);
    cyc(0, 0, 0, 1, 1, 0, 10'h055);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 10'h155);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 17; i++) cyc(1, 0, 0, 0, 1, 10'($urandom), 0);
    repeat (10) cyc(0, 0, 0, 1, 1, 0, 0);
    for (int ep = 0; ep < 20; ep++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      pct = ep % 2 ? 55 : 30;
      ir = 0;
      repeat (80) begin
        c = 0; r = 0; ri = 0;
        case ($urandom % 100) inside
          [0:0]: begin c = 1; r = 1; end
          [1:1]: ri = 1;
          default: ;
        endcase
        if (!c && !ri) begin
          pct = pct;
          if ($urandom % 100 < pct) c = stk.size() < 16 || $urandom % 4 == 0;
          else if ($urandom % 100 < 40) begin
            if (m_isr && $urandom % 2 == 0) ri = 1;
            else if (stk.size() > 0) r = 1;
          end
        end
        if (!ir && $urandom % 10 == 0) ir = 1;
        cyc(c, r, ri, ir, 1, 10'($urandom), 10'($urandom));
        if (last_ack) ir = 0;
      end
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/control_pila.md
Name: control_pila

Overview:
- Sequencer for the 10-bit return-address stack of the single-cycle CPU.
- Owns every stack push and pop, and arbitrates between decoder requests (call, ret, reti) and the external interrupt line.
- Tracks stack occupancy itself so that over/underflow is prevented, never merely flagged.
- Drives the next-PC select, the stall line and a sticky fault.

Parameters:
ADDR_W, 10, width of PC and stack entries
DEPTH, 16, stack capacity in entries
INT_VEC, 10'h3F0, interrupt service routine entry address
CNT_W, 5, width of occupancy counter (holds 0..DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
call  in  1  decoded call instruction this cycle
ret  in  1  decoded return instruction this cycle
reti  in  1  decoded return-from-interrupt this cycle
pc_plus1  in  ADDR_W  return address for call
pc_next  in  ADDR_W  address CPU would fetch next (resume point for interrupt)
int_req  in  1  level interrupt request, held until int_ack
stack_top  in  ADDR_W  current top entry from the stack
push  out  1  stack push strobe
pop  out  1  stack pop strobe
push_addr  out  ADDR_W  data to push
pc_sel  out  2  00 sequential/decoder, 01 stack_top, 10 pc_vec
pc_vec  out  ADDR_W  constant INT_VEC
int_ack  out  1  one-cycle acknowledge of interrupt entry
stall  out  1  CPU must not update PC or architectural state
in_isr  out  1  inside interrupt service routine
depth  out  CNT_W  current stack occupancy
fault  out  1  sticky illegal-sequence indicator

Behaviour:
- reset low (async):
  - state=RUN; depth=0; in_isr=0; fault=0.
  - All strobes 0; pc_sel=00; stall=0.
- Strobe generation:
  - push, pop, pc_sel, int_ack and stall are combinational from state and inputs.
  - depth, in_isr, fault and state are registered.
- FSM states: RUN, INT_ENTRY, INT_JUMP, FAULT.
- RUN, priority order:
  1. call&&ret, call&&reti, or ret&&reti -> FAULT. No strobes.
  2. call:
     - depth==DEPTH -> FAULT, no push.
     - else push=1, push_addr=pc_plus1, depth+1. pc_sel stays 00; the decoder supplies the target.
  3. ret:
     - depth==0 -> FAULT.
     - else pop=1, pc_sel=01 (stack_top is valid before the edge), depth-1.
  4. reti:
     - !in_isr or depth==0 -> FAULT.
     - else pop=1, pc_sel=01, depth-1, in_isr cleared at edge.
  5. int_req && !in_isr && depth<DEPTH, with no call/ret/reti this cycle -> INT_ENTRY.
     - A pending int_req is deferred while any decoder request is active, while in_isr=1, or while depth==DEPTH. It is never dropped and never faults.
- INT_ENTRY (1 cycle):
  - stall=1; push=1; push_addr=pc_next (value captured on the RUN->INT_ENTRY edge into a register); depth+1.
  - Decoder inputs ignored.
  - -> INT_JUMP.
- INT_JUMP (1 cycle):
  - pc_sel=10; int_ack=1; stall=0.
  - in_isr set at edge -> RUN.
  - Decoder inputs ignored.
- Interrupt latency: int_req accepted in cycle N -> push at N+1 -> vector fetch and int_ack at N+2.
- FAULT: absorbing until reset.
  - stall=1, fault=1; push=pop=0; pc_sel=00; int_ack=0.
- Nesting: none. int_req is ignored while in_isr=1. call/ret inside the ISR behave normally.
- depth never wraps. It is checked against 0 and DEPTH before any strobe is issued.
- Reset mid-sequence (INT_ENTRY or INT_JUMP): returns to RUN immediately. No int_ack is issued; the interrupted push is discarded with depth=0.

Test Plan:
- Reset: assert reset low mid-run -> depth=0, in_isr=0, fault=0, pc_sel=00, all strobes 0 with no clock edge.
- Call/ret pair: call with pc_plus1=10'h012, next cycle ret with stack_top=10'h012 -> push=1 then pop=1 with pc_sel=01; depth 0->1->0.
- Overflow: 16 calls -> depth=16. 17th call -> no push, fault=1, stall=1, state stays FAULT for 10 cycles.
- Interrupt entry: int_req=1, pc_next=10'h055 in idle cycle N -> push with push_addr=10'h055 and stall=1 at N+1; pc_sel=10, int_ack=1, pc_vec=10'h3F0 at N+2; in_isr=1 after.
- Arbitration: int_req=1 concurrent with call -> call pushes in cycle N, interrupt accepted at N+1, int_ack at N+3. Then reti with stack_top=10'h055 -> pop, pc_sel=01, in_isr=0.
- Illegal reti: reti while in_isr=0 -> fault=1, no pop. Separately, reset low during INT_JUMP -> int_ack never asserted, depth=0.
